// File: rtl/mem_port_sequencer.sv
// Shares one single-ported memory between fetch and load/store; optional ack watchdog under MEM_PORT_SEQ_WDT_EN.
// Latency: 3 cycles per non-memory instruction, 4 per load/store, plus 1 per memory wait cycle.
// Backpressure: each request is held until mem_ack; without the watchdog it waits indefinitely.
module mem_port_sequencer #(
  parameter int WDT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [15:0] aluResult,
  input  logic [15:0] memWriteData,
  output logic [15:0] instruction,
  output logic [15:0] readData,
  output logic        commit,
  output logic [15:0] instret,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, DATA, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [15:0] daddr_q;
  logic        rd_q;
  logic        acc;
  logic        tmo;

  assign acc = mem_req && mem_ack;

`ifdef MEM_PORT_SEQ_WDT_EN
  localparam int CW = ($clog2(WDT_CYCLES + 1) > 8) ? $clog2(WDT_CYCLES + 1) : 8;
  logic [CW-1:0] wdt_cnt;
  logic          bus_err_q;

  // Fires on the last permitted request cycle so mem_req is held exactly WDT_CYCLES cycles.
  assign tmo     = mem_req && !mem_ack && (wdt_cnt == CW'(WDT_CYCLES - 1));
  assign bus_err = bus_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (!mem_req || mem_ack || tmo) wdt_cnt <= '0;
      else                            wdt_cnt <= wdt_cnt + CW'(1);
      if (tmo) bus_err_q <= 1'b1;
    end
  end
`else
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (acc) state_nxt = EXEC; else if (tmo) state_nxt = COMMIT;
      EXEC:    state_nxt = (memRead || memWrite) ? DATA : COMMIT;
      DATA:    if (acc || tmo) state_nxt = COMMIT;
      COMMIT:  state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch address comes straight from the PC register, which only moves on commit.
  assign mem_addr = (state == FETCH) ? pc : daddr_q;
  assign commit   = (state == COMMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instruction <= 16'h0000;
      readData    <= 16'h0000;
      instret     <= 16'h0000;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= 16'h0000;
      daddr_q     <= 16'h0000;
      rd_q        <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: mem_req <= 1'b1;
        FETCH: begin
          if (acc || tmo) begin
            mem_req     <= 1'b0;
            instruction <= acc ? mem_rdata : 16'h0000;
          end
        end
        EXEC: begin
          if (memRead || memWrite) begin
            mem_req   <= 1'b1;
            mem_we    <= memWrite;
            mem_wdata <= memWrite ? memWriteData : 16'h0000;
            daddr_q   <= aluResult;
            rd_q      <= memRead && !memWrite;
          end
        end
        DATA: begin
          if (acc || tmo) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 16'h0000;
            if (rd_q) readData <= acc ? mem_rdata : 16'h0000;
          end
        end
        COMMIT: begin
          instret <= instret + 16'd1;
          mem_req <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
